// File: rtl/lc4_cmp_arbiter.sv
// lc4_cmp_arbiter: two requesters share one registered LC4 compare unit.
// Round-robin grant, operands latched at accept, valid/ready response.
// Optional per-requester response counters: define CMP_ARB_STATS_EN.
module lc4_cmp_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req0_insn,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [15:0] req1_insn,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_nzp,
    output logic        busy
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant;
    logic        any_valid;
    logic        accept_ok;
    logic [15:0] op_a, op_b;
    logic [8:0]  op_insn;
    logic        op_id;
    logic [15:0] rhs;
    logic        cmp_eq, cmp_lt;
    logic [15:0] cmp_res;
    logic [2:0]  cmp_nzp;

    // insn[15:9] carries no meaning for the compare
    logic unused_insn_hi;
    assign unused_insn_hi = ^{req0_insn[15:9], req1_insn[15:9]};

    // Round-robin pick: on a tie the requester that did not win last time goes
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = ~req0_valid;
        accept_ok = (state == IDLE) || ((state == RESP) && rsp_ready);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = any_valid ? EVAL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; ready is gated by reset so nothing is taken while held
    always_comb begin
        req0_ready = rst_n & accept_ok & req0_valid & ~grant;
        req1_ready = rst_n & accept_ok & req1_valid &  grant;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // Latch the granted operation so requesters can drop their operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_insn    <= '0;
            op_id      <= 1'b0;
        end else if (accept_ok && any_valid) begin
            last_grant <= grant;
            op_id      <= grant;
            op_a       <= grant ? req1_a : req0_a;
            op_b       <= grant ? req1_b : req0_b;
            op_insn    <= grant ? req1_insn[8:0] : req0_insn[8:0];
        end
    end

    // Sub-op decode: bit 8 selects immediate, bit 7 selects unsigned
    always_comb begin
        if (op_insn[8]) rhs = op_insn[7] ? {9'b0, op_insn[6:0]}
                                         : {{9{op_insn[6]}}, op_insn[6:0]};
        else            rhs = op_b;
        cmp_eq = (op_a == rhs);
        cmp_lt = op_insn[7] ? (op_a < rhs) : ($signed(op_a) < $signed(rhs));
        if (cmp_eq) begin
            cmp_res = 16'h0000;
            cmp_nzp = 3'b010;
        end else if (cmp_lt) begin
            cmp_res = 16'hFFFF;
            cmp_nzp = 3'b100;
        end else begin
            cmp_res = 16'h0001;
            cmp_nzp = 3'b001;
        end
    end

    // Response registers load in EVAL and hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_nzp    <= '0;
            rsp_id     <= 1'b0;
        end else if (state == EVAL) begin
            rsp_result <= cmp_res;
            rsp_nzp    <= cmp_nzp;
            rsp_id     <= op_id;
        end
    end

`ifdef CMP_ARB_STATS_EN
    // Count completed responses per requester, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_id) cnt1 <= cnt1 + CNT_W'(1);
            else        cnt0 <= cnt0 + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
